alu_rs: RTL
===========

Name: alu_rs

Overview:
- Reservation station directly upstream of the ALU.
- Accepts dispatched ALU ops whose operands may still be pending on producer tags, and snoops the common data bus (CDB) to capture those operands.
- Issues at most one ready op per cycle to the ALU as registered tag/op/operand signals (alu_rs, alu_op, alu_vl, alu_vr).
- Entry tags are what the ALU returns as its rs, and what consumers match on the CDB.

Parameters:
- WIDTH, 32, operand/result width.
- RSBIT, 3, tag width; tag 0 means "no tag / value ready".
- ENTRIES, 4, number of station entries.
- TAG_BASE, 1, tag of entry 0; entry i owns tag TAG_BASE+i. Constraint: TAG_BASE >= 1 and TAG_BASE+ENTRIES-1 <= 2^RSBIT-1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- disp_valid  in  1  dispatch request
- disp_ready  out  1  a free entry exists (combinational from registered state)
- disp_tag  out  RSBIT  tag the next accepted dispatch will own; valid when disp_ready
- disp_op  in  4  ALU op code
- disp_vl  in  WIDTH  left operand value; meaningful when disp_ql==0
- disp_ql  in  RSBIT  left operand producer tag; 0 means ready
- disp_vr  in  WIDTH  right operand value; meaningful when disp_qr==0
- disp_qr  in  RSBIT  right operand producer tag; 0 means ready
- cdb_tag  in  RSBIT  broadcast result tag; 0 means idle
- cdb_val  in  WIDTH  broadcast result value
- alu_rs  out  RSBIT  issued tag; 0 means no issue this cycle
- alu_op  out  4  issued op
- alu_vl  out  WIDTH  issued left operand
- alu_vr  out  WIDTH  issued right operand
- occupancy  out  $clog2(ENTRIES+1)  number of busy entries

Behaviour:
- Entry state: busy, op, vl, ql, vr, qr.
- Reset:
  - all busy=0; alu_rs=0, alu_op=0, alu_vl=0, alu_vr=0; occupancy=0.
  - Reset mid-operation discards all pending entries; no issue occurs in the cycle after reset.
- Allocation:
  - disp_ready = any entry not busy.
  - disp_tag = TAG_BASE + index of the lowest-index free entry.
  - Dispatch accepted on a rising edge when disp_valid && disp_ready. disp_valid with disp_ready=0 is ignored; the producer must hold its request.
- Dispatch-time bypass: if disp_ql!=0 && disp_ql==cdb_tag in the accept cycle, store vl=cdb_val, ql=0. Same rule for the right operand.
- Snoop: every cycle, for each busy entry with ql!=0 && ql==cdb_tag, set vl<=cdb_val and ql<=0. Same rule for qr/vr. Both operands of one entry may capture the same broadcast.
- Issue select:
  - Lowest-index busy entry with ql==0 && qr==0, evaluated on registered state.
  - An operand captured at edge N makes its entry eligible for issue at edge N+1. There is no same-edge snoop-to-issue forwarding.
- Issue:
  - On the edge, alu_rs<=TAG_BASE+idx; alu_op/alu_vl/alu_vr load from the entry; the entry's busy<=0.
  - With no eligible entry: alu_rs<=0, and alu_op/vl/vr hold their previous values.
- Latency: a dispatch with both operands ready, accepted at edge N, is presented on alu_rs after edge N+1. The ALU result appears after edge N+2.
- A freed entry is visible in disp_ready/disp_tag the cycle after the issue edge. There is no same-edge reuse.
- Simultaneous events:
  - Dispatch into entry j and issue from entry k (j != k) on the same edge are both legal.
  - Dispatch plus snoop on the same edge are both legal.
  - occupancy updates by +1, -1, or 0 for dispatch and issue on the same edge.
- Full: occupancy==ENTRIES means disp_ready=0; state is unchanged by disp_valid.
- Empty: alu_rs stays 0 every cycle.
- An entry may wait on a tag owned by this same station; it is woken when that result returns on the CDB.
- Tags are unique while busy because an entry is never reallocated before it issues.

Test Plan:
- Reset, then dispatch op=ADD, vl=5, vr=7, ql=qr=0 at edge 1 -> disp_tag=1 before edge 1; alu_rs=1, alu_op=ADD, vl=5, vr=7 after edge 2; alu_rs=0 after edge 3.
- Dispatch with ql=6 and vr=3 ready; cdb_tag=6, cdb_val=0x10 two cycles later -> no issue until the edge after the capture; then alu_vl=0x10, alu_vr=3.
- Dispatch with ql=qr=5 while cdb_tag=5, cdb_val=0xAB in the same cycle -> bypass captures both operands; issue on the next edge with vl=vr=0xAB.
- Fill all 4 entries waiting on tag 7 -> disp_ready=0, occupancy=4, a fifth disp_valid is ignored. Broadcast cdb_tag=7 -> entries issue in order, tags 1,2,3,4, on consecutive cycles; disp_ready=1 the cycle after the first issue.
- Dispatch into the entry freed by an issue while another entry issues on the same edge -> occupancy stays constant; no tag is duplicated on alu_rs.
- rst asserted with 3 busy entries and one pending issue -> alu_rs=0 and occupancy=0 after the reset edge; no stale issue afterwards.

Source files
------------

// File: rtl/alu_rs_if.sv
// rtl/alu_rs_if.sv - dispatch, CDB snoop and ALU issue signals of the ALU reservation station
interface alu_rs_if #(
  parameter int WIDTH   = 32,
  parameter int RSBIT   = 3,
  parameter int ENTRIES = 4
);
  localparam int OCCW = $clog2(ENTRIES + 1);

  logic             disp_valid;
  logic             disp_ready;
  logic [RSBIT-1:0] disp_tag;
  logic [3:0]       disp_op;
  logic [WIDTH-1:0] disp_vl;
  logic [RSBIT-1:0] disp_ql;
  logic [WIDTH-1:0] disp_vr;
  logic [RSBIT-1:0] disp_qr;
  logic [RSBIT-1:0] cdb_tag;
  logic [WIDTH-1:0] cdb_val;
  logic [RSBIT-1:0] alu_rs;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_vl;
  logic [WIDTH-1:0] alu_vr;
  logic [OCCW-1:0]  occupancy;

  modport master (
    output disp_valid, disp_op, disp_vl, disp_ql, disp_vr, disp_qr, cdb_tag, cdb_val,
    input  disp_ready, disp_tag, alu_rs, alu_op, alu_vl, alu_vr, occupancy
  );

  modport slave (
    input  disp_valid, disp_op, disp_vl, disp_ql, disp_vr, disp_qr, cdb_tag, cdb_val,
    output disp_ready, disp_tag, alu_rs, alu_op, alu_vl, alu_vr, occupancy
  );
endinterface

// File: rtl/alu_rs.sv
// rtl/alu_rs.sv - reservation station feeding the ALU: captures operands from the CDB, issues one ready op per cycle
module alu_rs #(
  parameter int WIDTH    = 32,
  parameter int RSBIT    = 3,
  parameter int ENTRIES  = 4,
  parameter int TAG_BASE = 1
) (
  input  logic   clk,
  input  logic   rst,
  alu_rs_if.slave bus
);
  localparam int IDXW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int OCCW = $clog2(ENTRIES + 1);

  logic [ENTRIES-1:0] busy;
  logic [3:0]         op [ENTRIES];
  logic [WIDTH-1:0]   vl [ENTRIES];
  logic [WIDTH-1:0]   vr [ENTRIES];
  logic [RSBIT-1:0]   ql [ENTRIES];
  logic [RSBIT-1:0]   qr [ENTRIES];

  logic [RSBIT-1:0]   alu_rs_q;
  logic [3:0]         alu_op_q;
  logic [WIDTH-1:0]   alu_vl_q;
  logic [WIDTH-1:0]   alu_vr_q;

  logic               free_found;
  logic [IDXW-1:0]    free_idx;
  logic               iss_found;
  logic [IDXW-1:0]    iss_idx;
  logic [OCCW-1:0]    occ;
  logic               accept;
  logic               cap_l;
  logic               cap_r;

  // Descending scan so the lowest matching index wins.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    iss_found  = 1'b0;
    iss_idx    = '0;
    occ        = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_found = 1'b1;
        free_idx   = IDXW'(i);
      end
      if (busy[i] && ql[i] == '0 && qr[i] == '0) begin
        iss_found = 1'b1;
        iss_idx   = IDXW'(i);
      end
      occ = occ + OCCW'(busy[i]);
    end
  end

  assign accept = bus.disp_valid && free_found;
  assign cap_l  = (bus.disp_ql != '0) && (bus.disp_ql == bus.cdb_tag);
  assign cap_r  = (bus.disp_qr != '0) && (bus.disp_qr == bus.cdb_tag);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= '0;
      alu_rs_q <= '0;
      alu_op_q <= '0;
      alu_vl_q <= '0;
      alu_vr_q <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (busy[i] && ql[i] != '0 && ql[i] == bus.cdb_tag) begin
          vl[i] <= bus.cdb_val;
          ql[i] <= '0;
        end
        if (busy[i] && qr[i] != '0 && qr[i] == bus.cdb_tag) begin
          vr[i] <= bus.cdb_val;
          qr[i] <= '0;
        end
      end

      if (iss_found) begin
        busy[iss_idx] <= 1'b0;
        alu_rs_q      <= RSBIT'(TAG_BASE) + RSBIT'(iss_idx);
        alu_op_q      <= op[iss_idx];
        alu_vl_q      <= vl[iss_idx];
        alu_vr_q      <= vr[iss_idx];
      end else begin
        alu_rs_q <= '0;
      end

      // The free entry is never the issuing one, so no same-edge reuse.
      if (accept) begin
        busy[free_idx] <= 1'b1;
        op[free_idx]   <= bus.disp_op;
        vl[free_idx]   <= cap_l ? bus.cdb_val : bus.disp_vl;
        ql[free_idx]   <= cap_l ? '0 : bus.disp_ql;
        vr[free_idx]   <= cap_r ? bus.cdb_val : bus.disp_vr;
        qr[free_idx]   <= cap_r ? '0 : bus.disp_qr;
      end
    end
  end

  assign bus.disp_ready = free_found;
  assign bus.disp_tag   = RSBIT'(TAG_BASE) + RSBIT'(free_idx);
  assign bus.occupancy  = occ;
  assign bus.alu_rs     = alu_rs_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.alu_vl     = alu_vl_q;
  assign bus.alu_vr     = alu_vr_q;
endmodule
